// File: rtl/sram_resp.sv
// Block-RAM responder that mimics a 16-bit asynchronous SRAM on the pin side.
// Bus pins are synchronised, decoded into IDLE/WRITE/READ and served from an on-chip array.
module sram_resp #(
  parameter int ADDR_W = 10
) (
  input  logic        sys_clk_in,
  input  logic        sys_rst_in,
  input  logic [15:0] sram_addr,
  input  logic        sram_ce_n,
  input  logic        sram_oe_n,
  input  logic        sram_we_n,
  input  logic        sram_ub_n,
  input  logic        sram_lb_n,
  inout  wire  [15:0] sram_data,
  output logic [15:0] wr_cnt,
  output logic        err_oob
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef struct packed {
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WRITE,
    ACC_READ
  } acc_t;

  localparam bus_t IDLE_BUS = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1,
                                lb_n: 1'b1, addr: 16'h0000, data: 16'h0000};

  bus_t raw_bus;
  bus_t meta_q;
  bus_t s_q;

  acc_t acc;
  acc_t prev_acc;
  logic oob;
  logic wr_en;
  logic strobe_start;
  logic access;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_data;
  logic              rd_en;
  logic              bus_rd;
  logic [ADDR_W-1:0] word_addr;

  assign raw_bus = '{ce_n: sram_ce_n, oe_n: sram_oe_n, we_n: sram_we_n, ub_n: sram_ub_n,
                     lb_n: sram_lb_n, addr: sram_addr, data: sram_data};

  // Two-stage synchroniser; reset parks the control lines in the idle pattern.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk_in) begin
    if (sys_rst_in) begin
      meta_q <= IDLE_BUS;
      s_q    <= IDLE_BUS;
    end else begin
      meta_q <= raw_bus;
      s_q    <= meta_q;
    end
  end

  generate
    if (ADDR_W < 16) begin : g_oob
      assign oob = |s_q.addr[15:ADDR_W];
    end else begin : g_full
      assign oob = 1'b0;
    end
  endgenerate

  assign word_addr = s_q.addr[ADDR_W-1:0];

  always_ff @(posedge sys_clk_in) begin
    if (sys_rst_in) prev_acc <= ACC_IDLE;
    else            prev_acc <= acc;
  end

  // WRITE wins over READ because the initiator keeps oe_n low permanently.
  // NOTE: every always_comb output is given a default first so no latch can be inferred.
  always_comb begin
    acc          = ACC_IDLE;
    wr_en        = 1'b0;
    strobe_start = 1'b0;
    access       = 1'b0;
    if (!s_q.ce_n && !s_q.we_n)      acc = ACC_WRITE;
    else if (!s_q.ce_n && !s_q.oe_n) acc = ACC_READ;
    access       = (acc != ACC_IDLE);
    wr_en        = (acc == ACC_WRITE) && !oob;
    strobe_start = (acc == ACC_WRITE) && (prev_acc != ACC_WRITE);
  end

  // NOTE: the array is deliberately not reset; reset only blocks writes so block RAM is inferred.
  always_ff @(posedge sys_clk_in) begin
    if (!sys_rst_in && wr_en) begin
      if (!s_q.ub_n) mem[word_addr][15:8] <= s_q.data[15:8];
      if (!s_q.lb_n) mem[word_addr][7:0]  <= s_q.data[7:0];
    end
    if (acc == ACC_READ) rd_data <= oob ? 16'h0000 : mem[word_addr];
  end

  always_ff @(posedge sys_clk_in) begin
    if (sys_rst_in) begin
      rd_en   <= 1'b0;
      wr_cnt  <= 16'h0000;
      err_oob <= 1'b0;
    end else begin
      rd_en <= (acc == ACC_READ);
      if (strobe_start)  wr_cnt  <= wr_cnt + 16'd1;
      if (access && oob) err_oob <= 1'b1;
    end
  end

  // Raw pins gate the driver so the bus is released in the very cycle we_n falls.
  assign bus_rd          = rd_en && !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_data[15:8] = (bus_rd && !sram_ub_n) ? rd_data[15:8] : 8'hzz;
  assign sram_data[7:0]  = (bus_rd && !sram_lb_n) ? rd_data[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_resp.sv
// Self-checking bench for sram_resp: directed test-plan sequences with literal
// expectations, then a bulk fill and randomized pin traffic against a reference model.
module tb_sram_resp;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  typedef struct packed {
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;
    logic [15:0] addr;
    logic [15:0] data;
  } pins_t;

  localparam pins_t IDLE_PINS = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1,
                                  lb_n: 1'b1, addr: 16'h0000, data: 16'h0000};

  logic        sys_clk_in = 1'b0;
  logic        sys_rst_in;
  logic [15:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  wire  [15:0] sram_data;
  logic [15:0] wr_cnt;
  logic        err_oob;

  logic [15:0] tb_data;
  logic        tb_quiet;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk_in = ~sys_clk_in;

  // The initiator drives data whenever it holds we_n low (unless told to stay quiet).
  assign sram_data = (!sram_we_n && !tb_quiet) ? tb_data : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (sram_data[i]);
  end

  sram_resp #(.ADDR_W(ADDR_W)) dut (
    .sys_clk_in (sys_clk_in),
    .sys_rst_in (sys_rst_in),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_data  (sram_data),
    .wr_cnt     (wr_cnt),
    .err_oob    (err_oob)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin values take effect two edges after they are sampled; the queue is that delay.
  pins_t       pipe[$];
  pins_t       s;
  logic [15:0] mm [DEPTH];
  bit   [1:0]  mk [DEPTH];
  logic [15:0] m_cnt;
  logic        m_oob;
  logic        m_rd_en;
  logic [15:0] m_rd;
  bit   [1:0]  m_rk;
  logic        m_prev_w;
  bit          model_live = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) mk[i] = 2'b00;

  function automatic pins_t cur_pins();
    pins_t p;
    p.ce_n = sram_ce_n;
    p.oe_n = sram_oe_n;
    p.we_n = sram_we_n;
    p.ub_n = sram_ub_n;
    p.lb_n = sram_lb_n;
    p.addr = sram_addr;
    p.data = (!sram_we_n && !tb_quiet) ? tb_data : 16'hFFFF;
    return p;
  endfunction

  always @(posedge sys_clk_in) begin
    if (sys_rst_in) begin
      pipe.delete();
      pipe.push_back(IDLE_PINS);
      pipe.push_back(IDLE_PINS);
      m_cnt      = 16'h0000;
      m_oob      = 1'b0;
      m_rd_en    = 1'b0;
      m_prev_w   = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      logic is_w, is_r, out_of_range;
      int   idx;
      s = pipe.pop_front();
      pipe.push_back(cur_pins());
      is_w         = !s.ce_n && !s.we_n;
      is_r         = !s.ce_n && s.we_n && !s.oe_n;
      out_of_range = (s.addr >= 16'(DEPTH));
      idx          = int'(s.addr) % DEPTH;
      if ((is_w || is_r) && out_of_range) m_oob = 1'b1;
      if (is_w && !out_of_range) begin
        if (!s.ub_n) begin mm[idx][15:8] = s.data[15:8]; mk[idx][1] = 1'b1; end
        if (!s.lb_n) begin mm[idx][7:0]  = s.data[7:0];  mk[idx][0] = 1'b1; end
      end
      if (is_w && !m_prev_w) m_cnt = m_cnt + 16'd1;
      m_prev_w = is_w;
      m_rd_en  = is_r;
      if (is_r) begin
        if (out_of_range) begin m_rd = 16'h0000;  m_rk = 2'b11;   end
        else              begin m_rd = mm[idx];   m_rk = mk[idx]; end
      end
    end
  end

  function automatic logic [15:0] exp_bus();
    logic [15:0] e;
    logic dut_drv, tb_drv;
    dut_drv = m_rd_en && !sram_ce_n && !sram_oe_n && sram_we_n;
    tb_drv  = !sram_we_n && !tb_quiet;
    if (dut_drv && !sram_ub_n) e[15:8] = m_rd[15:8];
    else if (tb_drv)           e[15:8] = tb_data[15:8];
    else                       e[15:8] = 8'hFF;
    if (dut_drv && !sram_lb_n) e[7:0] = m_rd[7:0];
    else if (tb_drv)           e[7:0] = tb_data[7:0];
    else                       e[7:0] = 8'hFF;
    return e;
  endfunction

  function automatic logic [15:0] bus_mask();
    logic [15:0] m;
    logic dut_drv;
    dut_drv = m_rd_en && !sram_ce_n && !sram_oe_n && sram_we_n;
    m = 16'hFFFF;
    if (dut_drv && !sram_ub_n && !m_rk[1]) m[15:8] = 8'h00;
    if (dut_drv && !sram_lb_n && !m_rk[0]) m[7:0]  = 8'h00;
    return m;
  endfunction

  // Compare process: shortly after every clock edge, including the edges where pins change.
  always @(sys_clk_in) begin
    #2;
    if (model_live) begin
      check("wr_cnt", {16'h0, wr_cnt}, {16'h0, m_cnt});
      check("err_oob", {31'h0, err_oob}, {31'h0, m_oob});
      check("bus", {16'h0, sram_data & bus_mask()}, {16'h0, exp_bus() & bus_mask()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_bus(input logic ce, input logic oe, input logic we, input logic ub,
                         input logic lb, input logic [15:0] a, input logic [15:0] d);
    sram_ce_n = ce;
    sram_oe_n = oe;
    sram_we_n = we;
    sram_ub_n = ub;
    sram_lb_n = lb;
    sram_addr = a;
    tb_data   = d;
  endtask

  // Lets n rising edges pass and returns on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge sys_clk_in);
    @(negedge sys_clk_in);
  endtask

  task automatic go_idle(input int n);
    set_bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    edges(n);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic ub, input logic lb,
                    input int n);
    set_bus(1'b0, 1'b0, 1'b0, ub, lb, a, d);
    edges(n);
    go_idle(3);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, 16'h0000);
    edges(3);
    check(name, {16'h0, sram_data}, {16'h0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ce, oe, we, ub, lb;
    logic [15:0] a;

    tb_quiet   = 1'b0;
    sys_rst_in = 1'b1;
    set_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
    edges(3);
    sys_rst_in = 1'b0;
    go_idle(1);
    check("reset_cnt", {16'h0, wr_cnt}, 32'h0);
    check("reset_oob", {31'h0, err_oob}, 32'h0);
    check("reset_bus_z", {16'h0, sram_data}, 32'hFFFF);

    // Basic write then read straight after the strobe.
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h1234);
    edges(2);
    set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000);
    edges(3);
    check("basic_rd", {16'h0, sram_data}, 32'h1234);
    check("basic_cnt", {16'h0, wr_cnt}, 32'h1);
    go_idle(1);

    // Byte lanes.
    wr(16'h0010, 16'hAAAA, 1'b0, 1'b0, 2);
    wr(16'h0010, 16'h5566, 1'b0, 1'b1, 1);
    rd_chk("lane_rd", 16'h0010, 16'h55AA);
    set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    #1;
    check("lane_lo_z", {24'h0, sram_data[7:0]}, 32'hFF);
    check("lane_hi", {24'h0, sram_data[15:8]}, 32'h55);
    edges(1);
    check("lane_cnt", {16'h0, wr_cnt}, 32'h3);

    // Burst of four words under one strobe.
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(i), 16'(16'h0100 + i));
      edges(1);
    end
    go_idle(3);
    for (int i = 0; i < 4; i++) rd_chk("burst_rd", 16'(i), 16'(16'h0100 + i));
    check("burst_cnt", {16'h0, wr_cnt}, 32'h4);

    // Out of range.
    go_idle(1);
    check("oob_clear", {31'h0, err_oob}, 32'h0);
    wr(16'h8000, 16'hBEEF, 1'b0, 1'b0, 1);
    check("oob_flag", {31'h0, err_oob}, 32'h1);
    check("oob_cnt", {16'h0, wr_cnt}, 32'h5);
    rd_chk("oob_rd", 16'h8000, 16'h0000);
    rd_chk("oob_keep0", 16'h0000, 16'h0100);

    // Contention: oe_n stays low, we_n falls while the responder is driving.
    rd_chk("cont_pre", 16'h0005, 16'h1234);
    tb_quiet = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000);
    #1;
    check("cont_release", {16'h0, sram_data}, 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      edges(1);
      check("cont_hold_z", {16'h0, sram_data}, 32'hFFFF);
    end
    go_idle(3);
    tb_quiet = 1'b0;

    // Reset during a strobe: nothing written, counter cleared.
    wr(16'h0020, 16'h1111, 1'b0, 1'b0, 1);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h2222);
    edges(1);
    sys_rst_in = 1'b1;
    edges(3);
    check("rst_cnt", {16'h0, wr_cnt}, 32'h0);
    check("rst_oob", {31'h0, err_oob}, 32'h0);
    sys_rst_in = 1'b0;
    rd_chk("rst_nowrite", 16'h0020, 16'h1111);
    check("rst_cnt_after", {16'h0, wr_cnt}, 32'h0);

    // Strobe held across reset release counts once and writes.
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h3333);
    edges(1);
    sys_rst_in = 1'b1;
    edges(2);
    sys_rst_in = 1'b0;
    edges(4);
    go_idle(2);
    check("rst_held_cnt", {16'h0, wr_cnt}, 32'h1);
    rd_chk("rst_held_wr", 16'h0020, 16'h3333);

    // Fill the whole array under one strobe so every location is known.
    for (int i = 0; i < DEPTH; i++) begin
      set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(i), 16'($urandom));
      edges(1);
    end
    go_idle(3);
    check("fill_cnt", {16'h0, wr_cnt}, 32'h2);

    // Randomized traffic; the compare process checks every edge.
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 149) == 0) begin
        sys_rst_in = 1'b1;
        edges($urandom_range(1, 2));
        sys_rst_in = 1'b0;
      end
      ce = ($urandom_range(0, 4) == 0);
      we = 1'($urandom_range(0, 1));
      oe = ($urandom_range(0, 5) == 0);
      ub = ($urandom_range(0, 3) == 0);
      lb = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       a = {6'($urandom_range(1, 63)), 10'($urandom_range(0, 1023))};
        1, 2, 3: a = 16'($urandom_range(0, 15));
        default: a = 16'($urandom_range(0, 1023));
      endcase
      tb_quiet = ($urandom_range(0, 9) == 0);
      set_bus(ce, oe, we, ub, lb, a, 16'($urandom));
      edges($urandom_range(1, 3));
    end
    tb_quiet = 1'b0;
    go_idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_resp.md
# sram_resp

Synthesizable responder for the board's 16-bit asynchronous SRAM bus: it presents the SRAM-side pin protocol (`ce_n`, `oe_n`, `we_n`, `ub_n`, `lb_n`, address, bidirectional data) in front of an on-chip block-RAM array. It lets the SRAM write/read controller and the seven-segment display path run on-chip, with no external SRAM fitted. It also reports write activity and out-of-range accesses for debug.

## Interface
- `ADDR_W`, 10: implemented depth is 2^ADDR_W words of 16 bits; legal range 4..16.
- `sys_clk_in`  in  1  system clock; all logic on its rising edge.
- `sys_rst_in`  in  1  reset, synchronous, active-high.
- `sram_addr`  in  16  word address from the initiator.
- `sram_ce_n`  in  1  chip enable, active-low.
- `sram_oe_n`  in  1  output enable, active-low.
- `sram_we_n`  in  1  write enable, active-low.
- `sram_ub_n`  in  1  upper byte lane `[15:8]` enable, active-low.
- `sram_lb_n`  in  1  lower byte lane `[7:0]` enable, active-low.
- `sram_data`  inout  16  data bus; driven per byte lane during reads, otherwise Z.
- `wr_cnt`  out  16  count of write strobes, wraps at 0xFFFF -> 0x0000.
- `err_oob`  out  1  sticky flag: an access hit an address at or above 2^ADDR_W.

## Operation
- **Input synchronisation:** all bus inputs pass through a 2-flop synchroniser. `sram_data` is sampled through the same stages. All decisions below use the synchronised ("s_") values unless stated otherwise.
- **Access states**, decoded every cycle from the `s_` values:
  - IDLE: `ce_n`=1, or (`we_n`=1 and `oe_n`=1).
  - WRITE: `ce_n`=0 and `we_n`=0. WRITE takes priority regardless of `oe_n`; the initiator holds `oe_n` low permanently.
  - READ: `ce_n`=0, `we_n`=1, `oe_n`=0.
- **Write:**
  - Every cycle in WRITE, the array is written at `s_addr[ADDR_W-1:0]` with `s_data`.
  - Upper byte is written only if `s_ub_n`=0; lower byte only if `s_lb_n`=0.
  - Holding `we_n` low while the address changes writes every address presented, as a real SRAM does.
- **Write counting:** `wr_cnt` increments by 1 on each IDLE/READ -> WRITE transition, i.e. per strobe, not per word.
- **Read:**
  - In READ, the array is read at `s_addr`; output data is registered.
  - The registered read-enable is qualified combinationally by the raw pins: the bus is driven only while raw `sram_ce_n`=0, `sram_oe_n`=0 and `sram_we_n`=1.
  - Effect: the responder releases the bus in the same cycle the initiator drops `we_n`, with no contention window.
  - Byte `[15:8]` is driven only when raw `sram_ub_n`=0; byte `[7:0]` only when raw `sram_lb_n`=0. A disabled byte stays Z.
- **Out of range:** if any `s_addr` bit at or above ADDR_W is 1:
  - writes are suppressed;
  - reads drive 16'h0000;
  - `err_oob` is set and stays set until reset.
  - When ADDR_W=16 no access is out of range.
- **Reset:**
  - `wr_cnt`=0, `err_oob`=0.
  - Read-enable register cleared, so `sram_data` is Z.
  - Synchroniser flops load the idle pattern: `ce_n`, `oe_n`, `we_n`, `ub_n`, `lb_n` = 1.
  - Array contents are not cleared.
  - Reset asserted mid-write suppresses array writes from that edge onward. After release, writes resume once the sampled `we_n`=0 reaches the `s_` stage: 2 edges.
  - A strobe already in progress at reset release counts as a new strobe.
- **Read/write hazard:** a READ cycle directly after WRITE to the same address returns the newly written data. The read pipeline starts only after `s_we_n`=1, which is later than the final write edge.

## Timing
- **Write latency:** pin values stable before edge N are in the array after edge N+2 (2 synchroniser edges + 1 write edge).
- **Read latency:** address, or `oe_n`/`we_n` entering READ, stable before edge N gives valid data on `sram_data` after edge N+2.
  - Data can lag an address change by up to 3 edges.
  - Initiators must hold the address at least 3 cycles before using read data.
- **Bus release:** combinational from raw `we_n`/`oe_n`/`ce_n`/`ub_n`/`lb_n`, i.e. 0 cycles.
- **Write strobe minimum:** 1 cycle. Pulses shorter than one `sys_clk_in` period may be missed.
- **Counters:** `wr_cnt` and `err_oob` update at edge N+2 relative to the pin event that caused them.

## Test plan
- **Basic write/read:** write addr 0x0005 data 0x1234 (`we_n` low 2 cycles), then `we_n`=1, `oe_n`=0 -> `sram_data`=0x1234 by the 3rd edge; `wr_cnt`=1.
- **Byte lanes:** preload 0x0010 with 0xAAAA, then write 0x5566 with `ub_n`=0, `lb_n`=1 -> read returns 0x55AA. Read with `lb_n`=1 -> `sram_data[7:0]`=Z.
- **Burst under one strobe:** `we_n` held low 4 cycles while addr steps 0,1,2,3 with data 0x0100+addr -> all four locations hold 0x0100..0x0103; `wr_cnt` increments by exactly 1.
- **Out of range (ADDR_W=10):** write 0x8000 data 0xBEEF -> location 0x0000 unchanged, `err_oob`=1. Read 0x8000 -> 0x0000.
- **Contention:** `oe_n`=0 throughout, toggle `we_n` 1->0 -> `sram_data` is Z in the same cycle; the responder never drives while `we_n`=0.
- **Reset mid-write:** assert `sys_rst_in` during a write strobe at addr 0x0020 -> from that edge no further writes, `wr_cnt`=0, bus Z. After release, the held strobe counts once.
